// File: rtl/secure_mem_decoder.sv
// -----------------------------------------------------------------------------
// secure_mem_decoder
//
// Read-side recovery engine for the secured memory write path. Protected words
// (address above ADDR_THRESH) were stored as Y = ((X-3)^2 + 9) * 3. This block
// recovers the positive root X with an iterative divide-by-3, an iterative
// integer square root and an exactness check. Unprotected words pass through
// unchanged. A key mismatch returns zero with key_err set.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   i_in_valid          request present
//   o_in_ready          request can be accepted (IDLE only)
//   i_data_in_memory    encoded word read from memory
//   i_key_access        access key, sampled at accept
//   i_read_address      word address, sampled at accept
//   o_out_valid         result available, held until i_out_ready
//   i_out_ready         consumer accepts the result
//   o_data_out          decoded or passthrough word
//   o_decode_err        protected word is not a legal encoding
//   o_key_err           key mismatch on this request
// -----------------------------------------------------------------------------
module secure_mem_decoder #(
    parameter logic [15:0] KEY         = 16'h0032,
    parameter int unsigned ADDR_THRESH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_data_in_memory,
    input  logic [15:0] i_key_access,
    input  logic [9:0]  i_read_address,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_data_out,
    output logic        o_decode_err,
    output logic        o_key_err
);

    typedef enum logic [2:0] {
        StIdle,
        StDiv,
        StSqrt,
        StCheck,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [4:0]  r_cnt;
    // Dividend shifts out at the MSB while quotient bits shift in at the LSB;
    // after 32 DIV cycles this register holds the quotient q.
    logic [31:0] r_dq;
    logic [1:0]  r_rem;
    // Radicand s = q - 9, consumed two bits per SQRT cycle from the top.
    logic [31:0] r_rad;
    logic [17:0] r_sq_rem;
    logic [15:0] r_root;

    logic [31:0] r_data_out;
    logic        r_decode_err;
    logic        r_key_err;

    logic        w_accept;
    logic        w_key_ok;
    logic        w_protected;

    logic [2:0]  w_div_trial;
    logic [2:0]  w_div_sub;
    logic        w_div_bit;
    logic [1:0]  w_div_rem_next;
    logic [31:0] w_q_next;

    logic [19:0] w_sq_acc;
    logic [19:0] w_sq_trial;
    logic [19:0] w_sq_diff;
    logic        w_sq_bit;

    logic [31:0] w_s;
    logic [31:0] w_root_sq;
    logic        w_legal;

    assign o_in_ready   = (r_state == StIdle);
    assign o_out_valid  = (r_state == StDone);
    assign o_data_out   = r_data_out;
    assign o_decode_err = r_decode_err;
    assign o_key_err    = r_key_err;

    assign w_accept    = i_in_valid & o_in_ready;
    assign w_key_ok    = (i_key_access == KEY);
    assign w_protected = ({22'b0, i_read_address} > ADDR_THRESH);

    // Restoring division by 3: partial remainder is always < 3, so 2 bits.
    assign w_div_trial    = {r_rem, r_dq[31]};
    assign w_div_sub      = w_div_trial - 3'd3;
    assign w_div_bit      = (w_div_trial >= 3'd3);
    assign w_div_rem_next = w_div_bit ? w_div_sub[1:0] : w_div_trial[1:0];
    assign w_q_next       = {r_dq[30:0], w_div_bit};

    // Digit-by-digit square root: try subtracting (4*root + 1) from the
    // remainder extended by the next two radicand bits.
    assign w_sq_acc   = {r_sq_rem, r_rad[31:30]};
    assign w_sq_trial = {2'b00, r_root, 2'b01};
    assign w_sq_diff  = w_sq_acc - w_sq_trial;
    assign w_sq_bit   = (w_sq_acc >= w_sq_trial);

    // q < 9 makes w_s meaningless, but the q >= 9 term already rejects it.
    assign w_s       = r_dq - 32'd9;
    assign w_root_sq = 32'(r_root) * 32'(r_root);
    assign w_legal   = (r_rem == 2'd0) && (r_dq >= 32'd9) && (w_root_sq == w_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    w_state_next = (w_key_ok && w_protected) ? StDiv : StDone;
                end
            end
            StDiv: begin
                if (r_cnt == 5'd31) begin
                    w_state_next = StSqrt;
                end
            end
            StSqrt: begin
                if (r_cnt == 5'd15) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                w_state_next = StDone;
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 5'd0;
            r_dq         <= 32'd0;
            r_rem        <= 2'd0;
            r_rad        <= 32'd0;
            r_sq_rem     <= 18'd0;
            r_root       <= 16'd0;
            r_data_out   <= 32'd0;
            r_decode_err <= 1'b0;
            r_key_err    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt    <= 5'd0;
                        r_dq     <= i_data_in_memory;
                        r_rem    <= 2'd0;
                        r_sq_rem <= 18'd0;
                        r_root   <= 16'd0;
                        if (!w_key_ok) begin
                            r_data_out   <= 32'd0;
                            r_decode_err <= 1'b0;
                            r_key_err    <= 1'b1;
                        end else if (!w_protected) begin
                            r_data_out   <= i_data_in_memory;
                            r_decode_err <= 1'b0;
                            r_key_err    <= 1'b0;
                        end
                    end
                end
                StDiv: begin
                    r_dq  <= w_q_next;
                    r_rem <= w_div_rem_next;
                    r_cnt <= r_cnt + 5'd1;  // wraps to 0 for the SQRT phase
                    if (r_cnt == 5'd31) begin
                        r_rad <= w_q_next - 32'd9;
                    end
                end
                StSqrt: begin
                    r_rad    <= {r_rad[29:0], 2'b00};
                    r_sq_rem <= w_sq_bit ? w_sq_diff[17:0] : w_sq_acc[17:0];
                    r_root   <= {r_root[14:0], w_sq_bit};
                    r_cnt    <= (r_cnt == 5'd15) ? 5'd0 : r_cnt + 5'd1;
                end
                StCheck: begin
                    r_key_err <= 1'b0;
                    if (w_legal) begin
                        r_data_out   <= {16'b0, r_root} + 32'd3;
                        r_decode_err <= 1'b0;
                    end else begin
                        r_data_out   <= 32'd0;
                        r_decode_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secure_mem_decoder.sv
// -----------------------------------------------------------------------------
// tb_secure_mem_decoder
//
// Self-checking bench for secure_mem_decoder: a table of directed vectors,
// hand-written reset-in-flight and back-to-back sequences, and randomized
// requests checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_secure_mem_decoder;

    localparam logic [15:0] KEY = 16'h0032;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_data_in_memory;
    logic [15:0] i_key_access;
    logic [9:0]  i_read_address;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_data_out;
    logic        o_decode_err;
    logic        o_key_err;

    int checks = 0;
    int errors = 0;

    secure_mem_decoder #(
        .KEY         (KEY),
        .ADDR_THRESH (128)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_in_valid       (i_in_valid),
        .o_in_ready       (o_in_ready),
        .i_data_in_memory (i_data_in_memory),
        .i_key_access     (i_key_access),
        .i_read_address   (i_read_address),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_data_out       (o_data_out),
        .o_decode_err     (o_decode_err),
        .o_key_err        (o_key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] key;
        logic [31:0] data;
        int          stall;
        logic [31:0] exp_data;
        logic        exp_derr;
        logic        exp_kerr;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] key;
        logic [31:0] data;
    } req_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: decode straight from the arithmetic definition of the encoding.
    function automatic void model(input logic [9:0] addr, input logic [15:0] key,
                                  input logic [31:0] data, output logic [31:0] ed,
                                  output logic ede, output logic eke, output int elat);
        longint d;
        longint q;
        longint s;
        longint r;
        ed   = 32'd0;
        ede  = 1'b0;
        eke  = 1'b0;
        elat = 0;
        d    = longint'({32'b0, data});
        if (key != KEY) begin
            eke = 1'b1;
        end else if (addr <= 10'd128) begin
            ed = data;
        end else begin
            elat = 49;
            q = d / 3;
            if ((d % 3) != 0 || q < 9) begin
                ede = 1'b1;
            end else begin
                s = q - 9;
                r = longint'($floor($sqrt(real'(s))));
                while (r * r > s) r--;
                while ((r + 1) * (r + 1) <= s) r++;
                if (r * r == s) ed = 32'(r) + 32'd3;
                else ede = 1'b1;
            end
        end
    endfunction

    // One full request: accept, wait for result, optional back-pressure, retire.
    task automatic run_req(input logic [9:0] addr, input logic [15:0] key,
                           input logic [31:0] data, input int stall,
                           input logic [31:0] ed, input logic ede, input logic eke,
                           input int elat, input string tag);
        int  lat;
        logic busy_ok;
        check({tag, " in_ready_idle"}, 32'(o_in_ready), 32'd1);
        i_read_address   = addr;
        i_key_access     = key;
        i_data_in_memory = data;
        i_in_valid       = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs: the DUT must have captured them at accept.
        i_in_valid       = 1'b0;
        i_data_in_memory = $urandom;
        i_key_access     = 16'($urandom);
        i_read_address   = 10'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!o_out_valid && lat < 100) begin
            if (o_in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " in_ready_busy"}, 32'(busy_ok), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " data_out"}, o_data_out, ed);
        check({tag, " decode_err"}, 32'(o_decode_err), 32'(ede));
        check({tag, " key_err"}, 32'(o_key_err), 32'(eke));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check({tag, " hold_valid"}, 32'(o_out_valid), 32'd1);
            check({tag, " hold_data"}, o_data_out, ed);
            check({tag, " hold_in_ready"}, 32'(o_in_ready), 32'd0);
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        check({tag, " retire_valid"}, 32'(o_out_valid), 32'd0);
        check({tag, " retire_in_ready"}, 32'(o_in_ready), 32'd1);
        check({tag, " retire_data_kept"}, o_data_out, ed);
    endtask

    vec_t        vecs[9];
    req_t        bb[3];
    int          acc_cyc[3];
    int          nacc;
    int          ndone;
    int          cyc;
    logic        will;
    logic [31:0] ed;
    logic        ede;
    logic        eke;
    int          elat;
    logic [9:0]  ra;
    logic [15:0] rk;
    logic [31:0] rd;
    longint      x;

    initial begin
        vecs[0] = '{10'd200,  KEY,      32'd174,          0, 32'd10,         1'b0, 1'b0, 49};
        vecs[1] = '{10'd200,  KEY,      32'd27,           0, 32'd3,          1'b0, 1'b0, 49};
        vecs[2] = '{10'd200,  KEY,      32'd30,           0, 32'd4,          1'b0, 1'b0, 49};
        vecs[3] = '{10'd1023, KEY,      32'h0300001B,     5, 32'h00001003,   1'b0, 1'b0, 49};
        vecs[4] = '{10'd129,  KEY,      32'd175,          0, 32'd0,          1'b1, 1'b0, 49};
        vecs[5] = '{10'd129,  KEY,      32'd24,           0, 32'd0,          1'b1, 1'b0, 49};
        vecs[6] = '{10'd129,  KEY,      32'd36,           0, 32'd0,          1'b1, 1'b0, 49};
        vecs[7] = '{10'd128,  KEY,      32'hDEADBEEF,     0, 32'hDEADBEEF,   1'b0, 1'b0, 0};
        vecs[8] = '{10'd200,  16'h0031, 32'd174,          1, 32'd0,          1'b0, 1'b1, 0};

        rst_n            = 1'b0;
        i_in_valid       = 1'b0;
        i_out_ready      = 1'b0;
        i_data_in_memory = 32'd0;
        i_key_access     = 16'd0;
        i_read_address   = 10'd0;
        #23;
        check("reset out_valid", 32'(o_out_valid), 32'd0);
        check("reset data_out", o_data_out, 32'd0);
        check("reset decode_err", 32'(o_decode_err), 32'd0);
        check("reset key_err", 32'(o_key_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 32'(o_in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i].addr, vecs[i].key, vecs[i].data, vecs[i].stall,
                    vecs[i].exp_data, vecs[i].exp_derr, vecs[i].exp_kerr,
                    vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset while the square-root phase is in flight.
        run_req(10'd100, KEY, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0, 0, "pre_rst");
        i_read_address   = 10'd200;
        i_key_access     = KEY;
        i_data_in_memory = 32'd174;
        i_in_valid       = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("midsqrt in_ready", 32'(o_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midsqrt rst out_valid", 32'(o_out_valid), 32'd0);
        check("midsqrt rst data_out", o_data_out, 32'd0);
        check("midsqrt rst decode_err", 32'(o_decode_err), 32'd0);
        check("midsqrt rst key_err", 32'(o_key_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midsqrt release in_ready", 32'(o_in_ready), 32'd1);
        run_req(10'd200, KEY, 32'd174, 0, 32'd10, 1'b0, 1'b0, 49, "post_rst");

        // Back-to-back: in_valid held high across three requests.
        bb[0] = '{10'd200, KEY, 32'd174};
        bb[1] = '{10'd128, KEY, 32'hCAFEF00D};
        bb[2] = '{10'd300, KEY, 32'h0300001B};
        nacc  = 0;
        ndone = 0;
        cyc   = 0;
        i_read_address   = bb[0].addr;
        i_key_access     = bb[0].key;
        i_data_in_memory = bb[0].data;
        i_in_valid       = 1'b1;
        i_out_ready      = 1'b1;
        while (ndone < 3 && cyc < 400) begin
            will = o_in_ready && i_in_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (will) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    i_read_address   = bb[nacc].addr;
                    i_key_access     = bb[nacc].key;
                    i_data_in_memory = bb[nacc].data;
                end else begin
                    i_in_valid = 1'b0;
                end
            end
            if (o_out_valid) begin
                model(bb[ndone].addr, bb[ndone].key, bb[ndone].data, ed, ede, eke, elat);
                check($sformatf("bb%0d data_out", ndone), o_data_out, ed);
                check($sformatf("bb%0d decode_err", ndone), 32'(o_decode_err), 32'(ede));
                check($sformatf("bb%0d key_err", ndone), 32'(o_key_err), 32'(eke));
                check($sformatf("bb%0d latency", ndone), 32'(cyc - acc_cyc[ndone]), 32'(elat));
                check($sformatf("bb%0d in_ready", ndone), 32'(o_in_ready), 32'd0);
                ndone++;
            end
        end
        check("bb results", 32'(ndone), 32'd3);
        check("bb accepts", 32'(nacc), 32'd3);
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;

        // Randomized requests against the arithmetic model.
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 10'($urandom_range(0, 128));
                1:       ra = ($urandom_range(0, 1) == 0) ? 10'd128 : 10'd129;
                default: ra = 10'($urandom_range(129, 1023));
            endcase
            rk = ($urandom_range(0, 7) == 0) ? 16'($urandom) : KEY;
            x  = longint'($urandom_range(3, 30000));
            case ($urandom_range(0, 3))
                0:       rd = 32'(((x - 3) * (x - 3) + 9) * 3);
                1:       rd = 32'(((x - 3) * (x - 3) + 9) * 3 + $urandom_range(1, 2));
                2:       rd = 32'($urandom_range(0, 60));
                default: rd = $urandom;
            endcase
            model(ra, rk, rd, ed, ede, eke, elat);
            run_req(ra, rk, rd, $urandom_range(0, 2), ed, ede, eke, elat,
                    $sformatf("rnd%0d a=%0d d=%h", n, ra, rd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secure_mem_decoder.md
Name: secure_mem_decoder

Overview:
- Read-side recovery engine for the secured memory write path.
- The write path stores protected words (write_address > 128, key 16'h0032) as Y = ((X-3)^2 + 9) * 3 and unprotected words unchanged.
- This block takes a word read back from memory and returns the original X (positive root) for protected addresses, or the word unchanged for unprotected ones.
- Sequential, multi-cycle: iterative divide-by-3, iterative integer square root, exactness check, valid/ready handshakes on both sides.

Parameters:
KEY, 16'h0032, access key that must match key_access for any decode.
ADDR_THRESH, 128, addresses strictly greater than this are treated as protected.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request; high only in IDLE.
data_in_memory  input  32  encoded word read from memory.
key_access  input  16  access key, sampled at accept.
read_address  input  10  address of the word, sampled at accept.
out_valid  output  1  result available; held until accepted.
out_ready  input  1  consumer accepts the result.
data_out  output  32  decoded or passthrough word.
decode_err  output  1  protected word is not a legal encoding.
key_err  output  1  key mismatch on this request.

Behaviour:
- Accept when in_valid & in_ready on a rising edge. All inputs are registered at accept; later input changes are ignored.
- States: IDLE, DIV, SQRT, CHECK, DONE.
- IDLE, key_access != KEY:
  - Go to DONE: data_out = 0, key_err = 1, decode_err = 0.
- IDLE, key OK and read_address <= ADDR_THRESH:
  - Go to DONE: data_out = data_in_memory, both error flags 0.
  - Latency: out_valid high in the cycle after the accept edge.
- IDLE, key OK and read_address > ADDR_THRESH: go to DIV.
- DIV: 32-cycle restoring division of the 32-bit word by 3, one quotient bit per cycle, MSB first. Produces q and a 2-bit remainder. Then go to SQRT.
- SQRT: 16-cycle bitwise non-restoring/restoring integer square root of s = q - 9 (32-bit), one root bit per cycle. Produces a 16-bit r = floor(sqrt(s)). Then go to CHECK.
- CHECK: 1 cycle. Legal iff remainder == 0, q >= 9, and r*r == s (16x16 unsigned multiply, 32-bit compare). Then go to DONE:
  - Legal: data_out = {16'b0, r} + 3, decode_err = 0.
  - Illegal: data_out = 0, decode_err = 1.
  - If q < 9, the subtraction result is don't-care, but the error must be flagged.
- Protected-path latency: out_valid first high after the 49th rising edge following the accept edge (32 DIV + 16 SQRT + 1 CHECK).
- DONE: out_valid = 1; data_out and both error flags are stable. On out_valid & out_ready, return to IDLE and clear out_valid; other outputs keep their values.
- in_ready = (state == IDLE). No new request is accepted while a result is pending, so there is no overlap.
- The negative root (3 - r) is never produced; only the positive root is defined.
- Reset (async, any state, including mid-DIV/SQRT):
  - State goes to IDLE.
  - out_valid = 0, data_out = 0, decode_err = 0, key_err = 0, in_ready = 1 after release.
  - The in-flight request is discarded.
- Encodings whose forward computation wrapped modulo 2^32 are not recovered. They decode per the rules above, normally to decode_err.

Test Plan:
- Reset then decode: key 16'h0032, addr 200, data 174 (X=10) -> out_valid 49 cycles after accept, data_out 10, errors 0. Also data 27 -> data_out 3; data 30 -> data_out 4.
- Large value: addr 1023, data 32'h0300001B -> data_out 32'h00001003, decode_err 0; out_ready held low 5 cycles -> out_valid and data_out held, in_ready low throughout.
- Illegal encodings at addr 129: 175 (rem != 0), 24 (q = 8 < 9), 36 (s = 3 not square) -> data_out 0, decode_err 1 for each.
- Boundary/passthrough: addr 128, data 32'hDEADBEEF -> data_out 32'hDEADBEEF one cycle after accept, no DIV/SQRT. Key 16'h0031 at addr 200 -> key_err 1, data_out 0, one-cycle latency.
- Reset mid-SQRT: assert rst_n low during cycle 40 of a decode -> outputs 0 immediately, IDLE after release, next request (data 174) decodes to 10 correctly.
- Back-to-back: in_valid held high with three requests, out_ready = 1 -> each accepted only in IDLE, results returned in order with correct latencies.
